// File: rtl/adder_tree_pkg.sv
// Shared constants and types for the adder_tree datapath and its operand loader.
package adder_tree_pkg;
   localparam int OPERAND_W    = 33;
   localparam int NUM_OPERANDS = 32;
   localparam int DATA_W       = OPERAND_W * NUM_OPERANDS;
   localparam int RESULT_W     = 38;
   localparam int CNT_W        = $clog2(NUM_OPERANDS);

   typedef enum logic {FILL, FULL} loader_state_t;
endpackage

// File: rtl/adder_tree_operand_loader.sv
// Packs a serial operand stream into one wide adder_tree word per clock_ena pulse.
// Define ADDER_TREE_LOADER_FLUSH_EN to let in_last close a word early (zero-padded).
module adder_tree_operand_loader
   import adder_tree_pkg::*;
(
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [OPERAND_W-1:0] in_data,
   input  logic                 in_last,
   input  logic                 hold,
   output logic [DATA_W-1:0]    data,
   output logic                 clock_ena,
   output logic [15:0]          words_issued
);

   loader_state_t     state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] buf_q, buf_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              ena_q, ena_d;
   logic [15:0]       words_q, words_d;

   logic              accept;
   logic              last_op;
   logic [DATA_W-1:0] fill_word;

   assign in_ready = (state_q == FILL);
   assign accept   = in_valid && in_ready;

`ifdef ADDER_TREE_LOADER_FLUSH_EN
   assign last_op = (cnt_q == CNT_W'(NUM_OPERANDS - 1)) || in_last;
`else
   logic unused_last;
   assign unused_last = in_last;
   assign last_op     = (cnt_q == CNT_W'(NUM_OPERANDS - 1));
`endif

   always_comb begin
      fill_word = buf_q;
      fill_word[cnt_q*OPERAND_W +: OPERAND_W] = in_data;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      buf_d   = buf_q;
      data_d  = data_q;
      ena_d   = 1'b0;
      words_d = words_q;
      unique case (state_q)
         FILL: begin
            if (accept) begin
               buf_d = fill_word;
               if (!last_op) begin
                  cnt_d = cnt_q + 1'b1;
               end else if (hold) begin
                  state_d = FULL;
               end else begin
                  data_d  = fill_word;
                  ena_d   = 1'b1;
                  cnt_d   = '0;
                  buf_d   = '0;
                  words_d = words_q + 16'd1;
               end
            end
         end
         FULL: begin
            // The completed word waits in buf_q until hold drops.
            if (!hold) begin
               state_d = FILL;
               data_d  = buf_q;
               ena_d   = 1'b1;
               cnt_d   = '0;
               buf_d   = '0;
               words_d = words_q + 16'd1;
            end
         end
         default: state_d = FILL;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= FILL;
         cnt_q   <= '0;
         buf_q   <= '0;
         data_q  <= '0;
         ena_q   <= 1'b0;
         words_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         buf_q   <= buf_d;
         data_q  <= data_d;
         ena_q   <= ena_d;
         words_q <= words_d;
      end
   end

   assign data         = data_q;
   assign clock_ena    = ena_q;
   assign words_issued = words_q;

endmodule
